// File: rtl/decodificador_display_pkg.sv
// Shared constants and types for the 7-segment bus receiver.
// Segment constants are active-high, bit0 = a .. bit6 = g.
package decodificador_display_pkg;

    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_A   = 7'h77;
    localparam logic [6:0] SEG_B   = 7'h7C;
    localparam logic [6:0] SEG_C   = 7'h39;
    localparam logic [6:0] SEG_D   = 7'h5E;
    localparam logic [6:0] SEG_E   = 7'h79;
    localparam logic [6:0] SEG_F   = 7'h71;
    localparam logic [6:0] SEG_OFF = 7'h00;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef logic [1:0] slot_t;

    typedef enum logic [1:0] {
        ESPERA   = 2'd0,
        ARMANDO  = 2'd1,
        COMPLETO = 2'd2
    } estado_t;

endpackage

// File: rtl/decodificador_segmentos.sv
// Combinational 7-segment pattern decoder (input already normalised to active-high).
// Optional macro DECODIFICAR_HEX_EN: letter patterns A,b,C,d,E,F decode to 4'hA..4'hF
// instead of being flagged invalid; an all-off pattern is always reported as blank.
module decodificador_segmentos
    import decodificador_display_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_bcd,
    output logic       o_blank,
    output logic       o_invalid
);

    // Pattern lookup; anything not in the table is an undecodable glyph.
    always_comb begin
        o_bcd     = BCD_BLANK;
        o_blank   = 1'b0;
        o_invalid = 1'b0;
        case (i_seg)
            SEG_0:   o_bcd = 4'd0;
            SEG_1:   o_bcd = 4'd1;
            SEG_2:   o_bcd = 4'd2;
            SEG_3:   o_bcd = 4'd3;
            SEG_4:   o_bcd = 4'd4;
            SEG_5:   o_bcd = 4'd5;
            SEG_6:   o_bcd = 4'd6;
            SEG_7:   o_bcd = 4'd7;
            SEG_8:   o_bcd = 4'd8;
            SEG_9:   o_bcd = 4'd9;
            SEG_OFF: o_blank = 1'b1;
`ifdef DECODIFICAR_HEX_EN
            SEG_A:   o_bcd = 4'hA;
            SEG_B:   o_bcd = 4'hB;
            SEG_C:   o_bcd = 4'hC;
            SEG_D:   o_bcd = 4'hD;
            SEG_E:   o_bcd = 4'hE;
            SEG_F:   o_bcd = 4'hF;
`endif
            default: o_invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/decodificador_display.sv
// Receive side of a 4-digit multiplexed 7-segment bus: rebuilds HH:MM as BCD,
// publishing only frames confirmed FRAMES_MATCH times in a row.
// Optional macro DECODIFICAR_HEX_EN (see decodificador_segmentos) enables hex letters.
module decodificador_display
    import decodificador_display_pkg::*;
#(
    parameter int STABLE_SAMPLES = 8,
    parameter int FRAMES_MATCH   = 2,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sw0,
    input  logic        sw1,
    input  logic        sw2,
    input  logic        sw3,
    input  logic [6:0]  displaytotal,
    input  logic        punto,
    output logic [15:0] digitos,
    output logic        punto_hora,
    output logic        valido,
    output logic        actualizado,
    output logic        error_seg,
    output logic        sin_senal
);

    localparam int STAB_W  = $clog2(STABLE_SAMPLES + 1);
    localparam int MATCH_W = $clog2(FRAMES_MATCH + 1);
    localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STAB_W-1:0]  STAB_MAX  = STAB_W'(STABLE_SAMPLES);
    localparam logic [STAB_W-1:0]  STAB_ONE  = STAB_W'(1);
    localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(FRAMES_MATCH);
    localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1);
    localparam logic [TMO_W-1:0]   TMO_MAX   = TMO_W'(TIMEOUT_CYCLES);

    // Sample layout: [11:8] sw3..sw0, [7:1] segments, [0] point
    logic [11:0]        r_sync1, r_sync2;
    logic [10:0]        r_last;
    logic [STAB_W-1:0]  r_stab, w_cnt;
    logic               r_hold;
    logic [TMO_W-1:0]   r_tmo;
    logic [3:0]         r_mask, w_mask_base, w_mask_next;
    estado_t            r_state, w_state_next;
    logic [MATCH_W-1:0] r_match, w_match_new;
    logic [3:0][3:0]    r_frame, r_prev_frame;
    logic               r_frame_pt, r_prev_pt;
    logic [15:0]        r_digitos;
    logic               r_punto_hora, r_valido, r_actualizado, r_error_seg, r_sin_senal;

    logic [6:0] w_seg;
    logic       w_pt_lit;
    logic [3:0] w_sel_low;
    slot_t      w_slot;
    logic       w_gap, w_same, w_sel_same, w_hold_eff, w_hit, w_capture, w_error, w_tmo_term;
    logic [3:0] w_bcd;
    logic       w_blank, w_invalid, w_frame_eq, w_confirm, w_publish;

    assign w_sel_low  = ~r_sync2[11:8];
    assign w_seg      = SEG_ACTIVE_LOW ? ~r_sync2[7:1] : r_sync2[7:1];
    assign w_pt_lit   = ~r_sync2[0];
    assign w_same     = (r_sync2[11:1] == r_last);
    assign w_sel_same = (r_sync2[11:8] == r_last[10:7]);

    decodificador_segmentos u_segmentos (
        .i_seg     (w_seg),
        .o_bcd     (w_bcd),
        .o_blank   (w_blank),
        .o_invalid (w_invalid)
    );

    // Two-flop synchronizer on every bus input.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {sw3, sw2, sw1, sw0, displaytotal, punto};
            r_sync2 <= r_sync1;
        end
    end

    // One-hot select decode; anything else is a gap between digits.
    always_comb begin
        w_gap  = 1'b0;
        w_slot = 2'd0;
        case (w_sel_low)
            4'b0001: w_slot = 2'd0;
            4'b0010: w_slot = 2'd1;
            4'b0100: w_slot = 2'd2;
            4'b1000: w_slot = 2'd3;
            default: w_gap  = 1'b1;
        endcase
    end

    // Count consecutive identical samples; a slot fires once until its select changes.
    always_comb begin
        if (w_gap)
            w_cnt = '0;
        else if (w_same)
            w_cnt = (r_stab == STAB_MAX) ? STAB_MAX : r_stab + 1'b1;
        else
            w_cnt = STAB_ONE;
        w_hold_eff = r_hold && w_sel_same && !w_gap;
        w_hit      = !w_gap && !w_hold_eff && (w_cnt == STAB_MAX);
        w_capture  = w_hit && !w_invalid;
        w_error    = w_hit && w_invalid;
        w_tmo_term = (r_tmo == TMO_MAX) && !w_hit;
    end

    // Stability tracking registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last <= '0;
            r_stab <= '0;
            r_hold <= 1'b0;
        end else begin
            r_last <= r_sync2[11:1];
            r_stab <= w_cnt;
            r_hold <= w_hit || w_hold_eff;
        end
    end

    // Dead-bus timer: restarts on every stable digit, parks at its terminal value.
    always_ff @(posedge clock) begin
        if (reset)
            r_tmo <= '0;
        else if (w_hit)
            r_tmo <= '0;
        else if (r_tmo != TMO_MAX)
            r_tmo <= r_tmo + 1'b1;
    end

    // Slot mask and frame FSM next state; COMPLETO lasts one cycle and restarts the mask.
    always_comb begin
        w_mask_base = (r_state == COMPLETO) ? 4'b0000 : r_mask;
        w_mask_next = w_mask_base;
        if (w_error)
            w_mask_next = 4'b0000;
        else if (w_capture)
            w_mask_next = w_mask_base | (4'b0001 << w_slot);
        if (w_tmo_term)
            w_mask_next = 4'b0000;

        w_state_next = ESPERA;
        case (r_state)
            ESPERA, ARMANDO: begin
                if (w_mask_next == 4'b1111)
                    w_state_next = COMPLETO;
                else if (w_mask_next != 4'b0000)
                    w_state_next = ARMANDO;
            end
            COMPLETO: begin
                if (w_mask_next != 4'b0000)
                    w_state_next = ARMANDO;
            end
            default: w_state_next = ESPERA;
        endcase
    end

    // FSM state and slot mask registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ESPERA;
            r_mask  <= 4'b0000;
        end else begin
            r_state <= w_state_next;
            r_mask  <= w_mask_next;
        end
    end

    // Frame confirmation: count repeats of the same complete frame.
    always_comb begin
        w_frame_eq  = (r_match != '0) && (r_frame == r_prev_frame) && (r_frame_pt == r_prev_pt);
        w_match_new = w_frame_eq ? ((r_match == MATCH_MAX) ? MATCH_MAX : r_match + 1'b1) : MATCH_ONE;
        w_confirm   = (r_state == COMPLETO) && (w_match_new >= MATCH_MAX);
        w_publish   = w_confirm && ((r_frame != r_digitos) || (r_frame_pt != r_punto_hora));
    end

    // Frame buffer and previous-frame copy; validity is tracked by mask and match counter.
    always_ff @(posedge clock) begin
        if (w_capture) begin
            r_frame[w_slot] <= w_blank ? BCD_BLANK : w_bcd;
            if (w_slot == 2'd2)
                r_frame_pt <= w_pt_lit;
        end
        if ((r_state == COMPLETO) && !w_frame_eq) begin
            r_prev_frame <= r_frame;
            r_prev_pt    <= r_frame_pt;
        end
    end

    // Match counter, cleared when the bus is declared dead.
    always_ff @(posedge clock) begin
        if (reset || w_tmo_term)
            r_match <= '0;
        else if (r_state == COMPLETO)
            r_match <= w_match_new;
    end

    // Published outputs and status pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_digitos     <= 16'h0000;
            r_punto_hora  <= 1'b0;
            r_valido      <= 1'b0;
            r_actualizado <= 1'b0;
            r_error_seg   <= 1'b0;
            r_sin_senal   <= 1'b0;
        end else begin
            r_actualizado <= w_publish;
            r_error_seg   <= w_error;
            if (w_publish) begin
                r_digitos    <= r_frame;
                r_punto_hora <= r_frame_pt;
            end
            if (w_tmo_term)
                r_valido <= 1'b0;
            else if (w_confirm)
                r_valido <= 1'b1;
            if (w_hit)
                r_sin_senal <= 1'b0;
            else if (w_tmo_term)
                r_sin_senal <= 1'b1;
        end
    end

    assign digitos     = r_digitos;
    assign punto_hora  = r_punto_hora;
    assign valido      = r_valido;
    assign actualizado = r_actualizado;
    assign error_seg   = r_error_seg;
    assign sin_senal   = r_sin_senal;

endmodule

// File: tb/tb_decodificador_display.sv
// Self-checking bench for decodificador_display: drives the multiplexed bus
// (active-low selects and segments) and scoreboards every published frame.
module tb_decodificador_display;

    localparam int TMO   = 2048;
    localparam int DWELL = 100;

    logic        clock = 1'b0;
    logic        reset;
    logic        sw0, sw1, sw2, sw3;
    logic [6:0]  displaytotal;
    logic        punto;
    logic [15:0] digitos;
    logic        punto_hora, valido, actualizado, error_seg, sin_senal;

    always #5 clock = ~clock;

    decodificador_display #(
        .STABLE_SAMPLES (8),
        .FRAMES_MATCH   (2),
        .TIMEOUT_CYCLES (TMO),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sw0          (sw0),
        .sw1          (sw1),
        .sw2          (sw2),
        .sw3          (sw3),
        .displaytotal (displaytotal),
        .punto        (punto),
        .digitos      (digitos),
        .punto_hora   (punto_hora),
        .valido       (valido),
        .actualizado  (actualizado),
        .error_seg    (error_seg),
        .sin_senal    (sin_senal)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int n_upd  = 0;
    int n_err  = 0;

    logic [16:0] exp_q[$];
    logic [16:0] m_prev = '0;
    logic [16:0] m_pub  = '0;
    int          m_match = 0;

    // Active-high glyph for a digit value; 4'hF is the blank (all off) glyph.
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b0111111;
            4'd1: return 7'b0000110;
            4'd2: return 7'b1011011;
            4'd3: return 7'b1001111;
            4'd4: return 7'b1100110;
            4'd5: return 7'b1101101;
            4'd6: return 7'b1111101;
            4'd7: return 7'b0000111;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1101111;
            4'hA: return 7'b1110111;
            default: return 7'b0000000;
        endcase
    endfunction

    // Reference behaviour for one complete, decodable frame {digits, point on digit2}.
    task automatic model_frame(input logic [16:0] f);
        if (m_match > 0 && f == m_prev) begin
            if (m_match < 2) m_match++;
        end else begin
            m_match = 1;
            m_prev  = f;
        end
        if (m_match >= 2 && f != m_pub) begin
            exp_q.push_back(f);
            m_pub = f;
        end
    endtask

    task automatic drive_slot(input int s, input logic [6:0] lit, input logic pt, input int cyc);
        @(negedge clock);
        sw0 = (s != 0);
        sw1 = (s != 1);
        sw2 = (s != 2);
        sw3 = (s != 3);
        displaytotal = ~lit;
        punto = ~pt;
        repeat (cyc - 1) @(negedge clock);
    endtask

    task automatic scan_frame(input logic [15:0] d, input logic pt2, input int dwell);
        model_frame({d, pt2});
        for (int s = 0; s < 4; s++)
            drive_slot(s, seg_of(d[4*s +: 4]), (s == 2) ? pt2 : 1'b0, dwell);
    endtask

    // Scoreboard: every update pulse must match the oldest expected frame.
    always @(negedge clock) begin
        logic [16:0] e;
        if (actualizado) begin
            n_upd++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_update got=%h/%b required=no pulse", digitos, punto_hora);
            end else begin
                e = exp_q.pop_front();
                if ({digitos, punto_hora} !== e) begin
                    n_fail++;
                    $display("FAIL publish got=%h/%b required=%h/%b", digitos, punto_hora, e[16:1], e[0]);
                end
            end
            n_cmp++;
            if (valido !== 1'b1) begin
                n_fail++;
                $display("FAIL valido_on_update got=%b required=1", valido);
            end
        end
        if (error_seg) begin
            n_err++;
            n_cmp++;
            if (actualizado !== 1'b0) begin
                n_fail++;
                $display("FAIL error_and_update_together got=%b required=0", actualizado);
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        sw0 = 1'b1; sw1 = 1'b1; sw2 = 1'b1; sw3 = 1'b1;
        displaytotal = 7'h7F;
        punto = 1'b1;
        repeat (4) @(negedge clock);
        n_cmp++; if (digitos !== 16'h0000) begin n_fail++; $display("FAIL reset_digitos got=%h required=0000", digitos); end
        n_cmp++; if (punto_hora !== 1'b0) begin n_fail++; $display("FAIL reset_punto_hora got=%b required=0", punto_hora); end
        n_cmp++; if (valido !== 1'b0) begin n_fail++; $display("FAIL reset_valido got=%b required=0", valido); end
        n_cmp++; if (actualizado !== 1'b0) begin n_fail++; $display("FAIL reset_actualizado got=%b required=0", actualizado); end
        n_cmp++; if (error_seg !== 1'b0) begin n_fail++; $display("FAIL reset_error_seg got=%b required=0", error_seg); end
        n_cmp++; if (sin_senal !== 1'b0) begin n_fail++; $display("FAIL reset_sin_senal got=%b required=0", sin_senal); end
        reset = 1'b0;
    endtask

    task automatic test_publish_1234();
        int u0 = n_upd;
        for (int f = 0; f < 3; f++) scan_frame(16'h1234, 1'b0, DWELL);
        repeat (20) @(negedge clock);
        n_cmp++; if (digitos !== 16'h1234) begin n_fail++; $display("FAIL first_digitos got=%h required=1234", digitos); end
        n_cmp++; if (valido !== 1'b1) begin n_fail++; $display("FAIL first_valido got=%b required=1", valido); end
        n_cmp++; if (n_upd - u0 != 1) begin n_fail++; $display("FAIL first_pulses got=%0d required=1", n_upd - u0); end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL first_pending got=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_change_and_glitch();
        int u0 = n_upd;
        for (int f = 0; f < 2; f++) scan_frame(16'h1235, 1'b0, DWELL);
        scan_frame(16'h9999, 1'b0, DWELL);
        repeat (20) @(negedge clock);
        n_cmp++; if (digitos !== 16'h1235) begin n_fail++; $display("FAIL change_digitos got=%h required=1235", digitos); end
        n_cmp++; if (n_upd - u0 != 1) begin n_fail++; $display("FAIL change_pulses got=%0d required=1", n_upd - u0); end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL change_pending got=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_error_seg();
        int e0 = n_err;
        drive_slot(0, seg_of(4'd4), 1'b0, DWELL);
        drive_slot(1, 7'b1000000, 1'b0, DWELL);
        drive_slot(2, seg_of(4'd2), 1'b0, DWELL);
        drive_slot(3, seg_of(4'd1), 1'b0, DWELL);
        n_cmp++; if (n_err - e0 != 1) begin n_fail++; $display("FAIL error_pulses got=%0d required=1", n_err - e0); end
        n_cmp++; if (digitos !== 16'h1235) begin n_fail++; $display("FAIL error_digitos got=%h required=1235", digitos); end
        n_cmp++; if (valido !== 1'b1) begin n_fail++; $display("FAIL error_valido got=%b required=1", valido); end
    endtask

    task automatic test_timeout();
        bit seen = 1'b0;
        for (int k = 0; k < 3 * TMO && !seen; k++) begin
            drive_slot((k / 5) % 4, seg_of(4'd8), 1'b0, 1);
            if (k == 500) begin
                n_cmp++;
                if (sin_senal !== 1'b0) begin n_fail++; $display("FAIL early_timeout got=%b required=0", sin_senal); end
            end
            if (sin_senal === 1'b1) seen = 1'b1;
        end
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL timeout_wait got=sin_senal 0 required=1 within %0d cycles", 3 * TMO); end
        n_cmp++; if (valido !== 1'b0) begin n_fail++; $display("FAIL timeout_valido got=%b required=0", valido); end
        n_cmp++; if (digitos !== 16'h1235) begin n_fail++; $display("FAIL timeout_digitos got=%h required=1235", digitos); end
        m_match = 0;
    endtask

    task automatic test_gap_and_blank();
        @(negedge clock);
        sw0 = 1'b0; sw1 = 1'b0; sw2 = 1'b1; sw3 = 1'b1;
        displaytotal = ~seg_of(4'd5);
        repeat (50) @(negedge clock);
        n_cmp++; if (sin_senal !== 1'b1) begin n_fail++; $display("FAIL gap_captured got=sin_senal %b required=1", sin_senal); end
        for (int f = 0; f < 3; f++) scan_frame(16'hFF34, 1'b0, DWELL);
        repeat (20) @(negedge clock);
        n_cmp++; if (digitos !== 16'hFF34) begin n_fail++; $display("FAIL blank_digitos got=%h required=FF34", digitos); end
        n_cmp++; if (sin_senal !== 1'b0) begin n_fail++; $display("FAIL blank_sin_senal got=%b required=0", sin_senal); end
        n_cmp++; if (valido !== 1'b1) begin n_fail++; $display("FAIL blank_valido got=%b required=1", valido); end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL blank_pending got=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_punto();
        for (int f = 0; f < 2; f++) scan_frame(16'h1234, 1'b1, DWELL);
        repeat (20) @(negedge clock);
        n_cmp++; if (punto_hora !== 1'b1) begin n_fail++; $display("FAIL punto_hora got=%b required=1", punto_hora); end
        n_cmp++; if (digitos !== 16'h1234) begin n_fail++; $display("FAIL punto_digitos got=%h required=1234", digitos); end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL punto_pending got=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_reset_midframe();
        drive_slot(0, seg_of(4'd4), 1'b0, DWELL);
        drive_slot(1, seg_of(4'd3), 1'b0, DWELL);
        reset = 1'b1;
        sw0 = 1'b1; sw1 = 1'b1; sw2 = 1'b1; sw3 = 1'b1;
        repeat (3) @(negedge clock);
        n_cmp++; if (digitos !== 16'h0000) begin n_fail++; $display("FAIL midreset_digitos got=%h required=0000", digitos); end
        n_cmp++; if (valido !== 1'b0) begin n_fail++; $display("FAIL midreset_valido got=%b required=0", valido); end
        n_cmp++; if (punto_hora !== 1'b0) begin n_fail++; $display("FAIL midreset_punto got=%b required=0", punto_hora); end
        n_cmp++; if (sin_senal !== 1'b0) begin n_fail++; $display("FAIL midreset_sin_senal got=%b required=0", sin_senal); end
        reset = 1'b0;
        m_match = 0;
        m_pub   = '0;
        for (int f = 0; f < 2; f++) scan_frame(16'h1234, 1'b0, DWELL);
        repeat (20) @(negedge clock);
        n_cmp++; if (digitos !== 16'h1234) begin n_fail++; $display("FAIL after_reset_digitos got=%h required=1234", digitos); end
        n_cmp++; if (valido !== 1'b1) begin n_fail++; $display("FAIL after_reset_valido got=%b required=1", valido); end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL after_reset_pending got=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_hex();
`ifdef DECODIFICAR_HEX_EN
        for (int f = 0; f < 2; f++) scan_frame(16'h123A, 1'b0, DWELL);
        repeat (20) @(negedge clock);
        n_cmp++; if (digitos !== 16'h123A) begin n_fail++; $display("FAIL hex_digitos got=%h required=123A", digitos); end
`else
        int e0 = n_err;
        drive_slot(0, seg_of(4'hA), 1'b0, DWELL);
        drive_slot(1, seg_of(4'd3), 1'b0, DWELL);
        drive_slot(2, seg_of(4'd2), 1'b0, DWELL);
        drive_slot(3, seg_of(4'd1), 1'b0, DWELL);
        n_cmp++; if (n_err - e0 != 1) begin n_fail++; $display("FAIL hex_error_pulses got=%0d required=1", n_err - e0); end
        n_cmp++; if (digitos !== 16'h1234) begin n_fail++; $display("FAIL hex_digitos got=%h required=1234", digitos); end
`endif
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL hex_pending got=%0d required=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_publish_1234();
        test_change_and_glitch();
        test_error_seg();
        test_timeout();
        test_gap_and_blank();
        test_punto();
        test_reset_midframe();
        test_hex();
        repeat (5) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
